fix_mult_pipe: RTL and testbench

FIX_MULT_PIPE -- requirements
Module: fix_mult_pipe

---
 rtl/fix_mult_pkg.sv | 9 +
 rtl/fix_sm_conv.sv | 22 ++
 rtl/fix_mult_pipe.sv | 120 ++++++++++++
 tb/tb_fix_mult_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_mult_pkg.sv
// Shared constants for the fixed-point multiplier pipeline: number formats,
// rounding modes and pipeline depth.
package fix_mult_pkg;
    localparam int FMT_SM    = 0;  // sign-magnitude operands and result
    localparam int FMT_TC    = 1;  // two's-complement operands and result
    localparam int RND_TRUNC = 0;  // truncate the magnitude
    localparam int RND_HAZ   = 1;  // round half away from zero
    localparam int N_STAGES  = 4;
endpackage

// File: rtl/fix_sm_conv.sv
// Splits one Q1.(DW-1) operand into a sign bit and an unsigned DW-bit magnitude.
module fix_sm_conv
    import fix_mult_pkg::*;
#(
    parameter int DW = 16,
    parameter int TC = FMT_SM
) (
    input  logic [DW-1:0] x,
    output logic          sign,
    output logic [DW-1:0] mag
);
    assign sign = x[DW-1];

    generate
        if (TC == FMT_TC) begin : g_tc
            // -1.0 becomes 2^(DW-1), which still fits the unsigned DW-bit magnitude.
            assign mag = x[DW-1] ? -x : x;
        end else begin : g_sm
            assign mag = {1'b0, x[DW-2:0]};
        end
    endgenerate
endmodule

// File: rtl/fix_mult_pipe.sv
// Four-stage fixed-point multiplier: capture, sign/magnitude split, magnitude multiply,
// then align/round/saturate/format. A single enable advances or freezes every stage.
module fix_mult_pipe
    import fix_mult_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OW  = 32,
    parameter int TC  = FMT_SM,
    parameter int RND = RND_HAZ
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] y_out,
    output logic          ovf,
    output logic          ovf_sticky,
    input  logic          ovf_clr
);
    localparam int PW = 2 * DW;
    localparam int FW = OW - 1;

    logic          en;
    logic          s1_valid, s2_valid, s3_valid;
    logic [DW-1:0] s1_a, s1_b;
    logic          sign_a, sign_b;
    logic [DW-1:0] mag_a, mag_b;
    logic          s2_sa, s2_sb;
    logic [DW-1:0] s2_ma, s2_mb;
    logic          s3_s;
    logic [PW-1:0] s3_p;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    fix_sm_conv #(.DW(DW), .TC(TC)) u_conv_a (.x(s1_a), .sign(sign_a), .mag(mag_a));
    fix_sm_conv #(.DW(DW), .TC(TC)) u_conv_b (.x(s1_b), .sign(sign_b), .mag(mag_b));

    // m is the product as Q2.(2DW-1); after the shift, kept[FW-1:0] is the retained
    // magnitude and any set bit above it means the result does not fit.
    logic [PW:0]   m, kept;
    logic          rbit, over, s_fin;
    logic [FW:0]   sum;
    logic [FW-1:0] mag_q;
    logic [OW-1:0] y_next;

    assign m    = {s3_p, 1'b0};
    assign kept = m >> (PW - OW);

    generate
        if (RND == RND_HAZ && OW < PW) begin : g_rnd
            assign rbit = m[PW-OW-1];
        end else begin : g_trunc
            assign rbit = 1'b0;
        end
    endgenerate

    assign sum   = {1'b0, kept[FW-1:0]} + {{FW{1'b0}}, rbit};
    assign over  = (|kept[PW:FW]) || sum[FW];
    assign mag_q = over ? {FW{1'b1}} : sum[FW-1:0];
    assign s_fin = s3_s && (|mag_q);

    generate
        if (TC == FMT_TC) begin : g_fmt_tc
            assign y_next = s_fin ? -{1'b0, mag_q} : {1'b0, mag_q};
        end else begin : g_fmt_sm
            assign y_next = {s_fin, mag_q};
        end
    endgenerate

    // NOTE: state uses non-blocking assignments so each stage samples last cycle's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            out_valid <= s3_valid;
            if (s3_valid) begin
                y_out <= y_next;
                ovf   <= over;
            end
        end
    end

    // NOTE: pipeline data registers have no reset; their valid bits decide whether they matter.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s2_sa <= sign_a;
            s2_sb <= sign_b;
            s2_ma <= mag_a;
            s2_mb <= mag_b;
            s3_s  <= s2_sa ^ s2_sb;
            s3_p  <= PW'(s2_ma) * PW'(s2_mb);
        end
    end

    // A set from a result leaving the block takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fix_mult_pipe.sv
// Drives four fix_mult_pipe configurations in lockstep and checks them against
// a scoreboard fed by an arithmetic reference model.
module tb_fix_mult_pipe;
    import fix_mult_pkg::*;

    localparam int CFG_OW  [4] = '{32, 32, 16, 16};
    localparam int CFG_TC  [4] = '{0, 1, 1, 1};
    localparam int CFG_RND [4] = '{1, 1, 1, 0};

    typedef struct packed {
        logic [3:0][31:0] y;
        logic [3:0]       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, ovf_clr;
    logic [15:0] in_a, in_b;
    logic [3:0]  ir, ov, ovf, stk;
    logic [31:0] y0, y1;
    logic [15:0] y2, y3;
    logic [3:0][31:0] y_all;

    int checks   = 0;
    int failures = 0;

    exp_t             sb_q[$];
    logic [3:0]       pipe;
    logic [3:0]       e_stk;
    logic [3:0][31:0] held_y;
    bit               stalled;

    assign y_all = {{16'h0, y3}, {16'h0, y2}, y1, y0};

    always #5 clk = ~clk;

    fix_mult_pipe #(.DW(16), .OW(32), .TC(FMT_SM), .RND(RND_HAZ)) u_sm32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
        .out_valid(ov[0]), .out_ready(out_ready), .y_out(y0), .ovf(ovf[0]),
        .ovf_sticky(stk[0]), .ovf_clr(ovf_clr));
    fix_mult_pipe #(.DW(16), .OW(32), .TC(FMT_TC), .RND(RND_HAZ)) u_tc32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
        .out_valid(ov[1]), .out_ready(out_ready), .y_out(y1), .ovf(ovf[1]),
        .ovf_sticky(stk[1]), .ovf_clr(ovf_clr));
    fix_mult_pipe #(.DW(16), .OW(16), .TC(FMT_TC), .RND(RND_HAZ)) u_tc16r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
        .out_valid(ov[2]), .out_ready(out_ready), .y_out(y2), .ovf(ovf[2]),
        .ovf_sticky(stk[2]), .ovf_clr(ovf_clr));
    fix_mult_pipe #(.DW(16), .OW(16), .TC(FMT_TC), .RND(RND_TRUNC)) u_tc16t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_a(in_a), .in_b(in_b),
        .out_valid(ov[3]), .out_ready(out_ready), .y_out(y3), .ovf(ovf[3]),
        .ovf_sticky(stk[3]), .ovf_clr(ovf_clr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product in units of 2^-30, rescaled to OW-1 fraction bits.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input int ow, input int tc, input int rnd,
                                  output logic [31:0] y, output logic v);
        longint ma, mb, p, mag, lim, yl;
        logic   sa, sb, s;
        int     sh;
        sa = a[15];
        sb = b[15];
        if (tc == 0) begin
            ma = longint'(a[14:0]);
            mb = longint'(b[14:0]);
        end else begin
            ma = sa ? (longint'(65536) - longint'(a)) : longint'(a);
            mb = sb ? (longint'(65536) - longint'(b)) : longint'(b);
        end
        p  = ma * mb;
        sh = 31 - ow;
        if (sh < 0) begin
            mag = p << (-sh);
        end else begin
            mag = p >> sh;
            if (rnd == 1 && sh > 0) mag = mag + ((p >> (sh - 1)) & 1);
        end
        lim = (longint'(1) << (ow - 1)) - 1;
        v   = (mag > lim);
        if (v) mag = lim;
        s = (sa ^ sb) && (mag != 0);
        if (tc == 0) yl = (longint'(s) << (ow - 1)) | mag;
        else         yl = s ? ((longint'(1) << ow) - mag) : mag;
        y = yl[31:0];
    endfunction

    function automatic exp_t predict(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] yy;
        logic        vv;
        for (int i = 0; i < 4; i++) begin
            model(a, b, CFG_OW[i], CFG_TC[i], CFG_RND[i], yy, vv);
            e.y[i] = yy;
            e.v[i] = vv;
        end
        return e;
    endfunction

    // Scoreboard monitor: models pipeline occupancy, sticky flags and output hold.
    initial begin : monitor
        logic e_ov, e_en;
        exp_t front;
        pipe    = '0;
        e_stk   = '0;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pipe    = '0;
                e_stk   = '0;
                stalled = 1'b0;
                sb_q.delete();
            end else begin
                e_ov = pipe[3];
                e_en = !e_ov || out_ready;
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(e_ov));
                    check($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(e_en));
                    check($sformatf("ovf_sticky[%0d]", i), 32'(stk[i]), 32'(e_stk[i]));
                    if (stalled) check($sformatf("hold_y[%0d]", i), y_all[i], held_y[i]);
                end
                if (e_ov) begin
                    check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        front = sb_q[0];
                        for (int i = 0; i < 4; i++) begin
                            check($sformatf("y_out[%0d]", i), y_all[i], front.y[i]);
                            check($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(front.v[i]));
                        end
                        for (int i = 0; i < 4; i++) begin
                            if (out_ready && front.v[i]) e_stk[i] = 1'b1;
                            else if (ovf_clr)            e_stk[i] = 1'b0;
                        end
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end else if (ovf_clr) begin
                    e_stk = '0;
                end
                stalled = e_ov && !out_ready;
                held_y  = y_all;
                if (in_valid && e_en) sb_q.push_back(predict(in_a, in_b));
                if (e_en) pipe = {pipe[2:0], in_valid};
            end
        end
    end

    // Presents one pair at posedge+1 and checks acceptance, latency and literal results.
    task automatic send_timed(input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] ey0, input logic [31:0] ey1,
                              input logic [31:0] ey2, input logic [31:0] ey3,
                              input logic [3:0] ev, input string tag);
        int   n, tries;
        bit   got;
        logic [3:0][31:0] ey;
        ey       = {ey3, ey2, ey1, ey0};
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        got      = 1'b0;
        tries    = 0;
        while (!got && tries < 50) begin
            @(negedge clk);
            got = in_ready_any();
            tries++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check({tag, "_accept_first_edge"}, 32'(tries), 32'd1);
        n   = 1;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (ov[0]) begin
                got = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("%s_y[%0d]", tag, i), y_all[i], ey[i]);
                    check($sformatf("%s_ovf[%0d]", tag, i), 32'(ovf[i]), 32'(ev[i]));
                end
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'(N_STAGES));
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_ready_any();
        return ir[0];
    endfunction

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || pipe != 4'b0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_drained"}, 32'(k < 200), 32'd1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 9))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0001;
            4:       return 16'h0000;
            5:       return 16'hC000;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] bp_a [8];
        logic [15:0] bp_b [8];
        int  idx, nsent;
        bit  acc;
        bp_a = '{16'h4000, 16'hC000, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0001, 16'h5A5A};
        bp_b = '{16'h2000, 16'h4000, 16'h7FFF, 16'h3333, 16'hABCD, 16'h8001, 16'h4000, 16'hA5A5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            check($sformatf("rst_y[%0d]", i), y_all[i], 32'd0);
            check($sformatf("rst_ovf[%0d]", i), 32'(ovf[i]), 32'd0);
            check($sformatf("rst_sticky[%0d]", i), 32'(stk[i]), 32'd0);
            check($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
        end
        rst = 1'b0;

        // Directed values, one result at a time.
        send_timed(16'h4000, 16'h4000, 32'h2000_0000, 32'h2000_0000, 32'h2000, 32'h2000, 4'b0000, "half_sq");
        send_timed(16'hC000, 16'h4000, 32'hA000_0000, 32'hE000_0000, 32'hE000, 32'hE000, 4'b0000, "neg_quarter");
        send_timed(16'h8000, 16'h1234, 32'h0000_0000, 32'hEDCC_0000, 32'hEDCC, 32'hEDCC, 4'b0000, "neg_zero_op");
        send_timed(16'h0001, 16'h4000, 32'h0000_8000, 32'h0000_8000, 32'h0001, 32'h0000, 4'b0000, "round_lsb");

        // -1.0 squared saturates; the clear held through its acceptance must lose to the set.
        ovf_clr = 1'b1;
        send_timed(16'h8000, 16'h8000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF, 32'h7FFF, 4'b1110, "neg1_sq");
        ovf_clr = 1'b0;
        check("sticky_set_wins_tc32", 32'(stk[1]), 32'd1);
        check("sticky_set_wins_tc16", 32'(stk[2]), 32'd1);
        check("sticky_untouched_sm32", 32'(stk[0]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("sticky_holds_tc32", 32'(stk[1]), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("sticky_cleared_tc32", 32'(stk[1]), 32'd0);

        // Backpressure: eight pairs with out_ready low for cycles 5..12.
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid  = (idx < 8);
            in_a      = bp_a[idx % 8];
            in_b      = bp_b[idx % 8];
            out_ready = !(c >= 5 && c <= 12);
            @(negedge clk);
            acc = in_valid && ir[0];
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_accepted", 32'(idx), 32'd8);
        drain("bp");

        // Random operands with random valid, backpressure and sticky clears.
        nsent = 0;
        for (int k = 0; k < 400 && nsent < 60; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = pick();
            in_b      = pick();
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            acc = in_valid && ir[0];
            @(posedge clk);
            #1;
            if (acc) nsent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        check("rand_sent", 32'(nsent), 32'd60);
        drain("rand");

        // Reset with results in flight: nothing stale may emerge afterwards.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a     = 16'h7FFF - 16'(k);
            in_b     = 16'h9000 + 16'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(ov[0]), 32'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("async_rst_out_valid[%0d]", i), 32'(ov[i]), 32'd0);
            check($sformatf("async_rst_y[%0d]", i), y_all[i], 32'd0);
        end
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 32'(ir[0]), 32'd1);
        in_valid = 1'b1;
        in_a     = 16'h4000;
        in_b     = 16'hC000;
        #2;
        rst = 1'b0;
        send_timed(16'h4000, 16'hC000, 32'hA000_0000, 32'hE000_0000, 32'hE000, 32'hE000, 4'b0000, "post_rst");
        drain("post_rst");
        repeat (6) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
